// File: rtl/gigatron_arb_pkg.sv
// Shared types for the Gigatron SRAM arbiter: FSM state, bus owner and
// the width of the steal counter.
package gigatron_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    STEAL = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } arb_owner_t;

  localparam int STEAL_CNT_W = 16;

endpackage

// File: rtl/gigatron_ram_arbiter.sv
// Shares the Gigatron's single asynchronous SRAM between the CPU and a host
// port. The CPU has priority; a starved host steals one cycle by stalling the CPU.
module gigatron_ram_arbiter
  import gigatron_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            cpu_addr,
  input  logic [7:0]             cpu_wdata,
  input  logic                   cpu_oe,
  input  logic                   cpu_we,
  output logic [7:0]             cpu_rdata,
  output logic                   cpu_ce,
  input  logic                   host_req,
  input  logic                   host_we,
  input  logic [15:0]            host_addr,
  input  logic [7:0]             host_wdata,
  output logic                   host_busy,
  output logic                   host_ack,
  output logic [7:0]             host_rdata,
  output logic [STEAL_CNT_W-1:0] steal_count,
  output logic [15:0]            sram_addr,
  output logic [7:0]             sram_wdata,
  input  logic [7:0]             sram_rdata,
  output logic                   sram_oe,
  output logic                   sram_we,
  output arb_state_t             dbg_state,
  output logic [7:0]             dbg_wait_cnt
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  // Host handshake: host_req is accepted only on a cycle where host_busy = 0
  // (this includes the host_ack cycle); host_ack then pulses for one cycle,
  // the cycle after the SRAM access was granted to the host.

  arb_state_t                 state_q, state_d;
  arb_owner_t                 owner;
  logic                       cpu_active;
  logic [7:0]                 wait_cnt_q, wait_cnt_d;
  logic                       pend_we_q, pend_we_d;
  logic [15:0]                pend_addr_q, pend_addr_d;
  logic [7:0]                 pend_wdata_q, pend_wdata_d;
  logic                       host_ack_q, host_ack_d;
  logic [7:0]                 host_rdata_q, host_rdata_d;
  logic [STEAL_CNT_W-1:0]     steal_count_q, steal_count_d;

  assign cpu_active = cpu_oe | cpu_we;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (host_req) state_d = PEND;
      end
      PEND: begin
        if (!cpu_active) begin
          state_d = IDLE;
        end else if (wait_cnt_q + 8'd1 == MAX_WAIT_C) begin
          state_d = STEAL;
        end
      end
      STEAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: ownership and the combinational SRAM mux
  always_comb begin
    owner      = OWN_NONE;
    cpu_ce     = 1'b1;
    host_busy  = 1'b0;
    sram_addr  = 16'h0000;
    sram_wdata = 8'h00;
    sram_oe    = 1'b0;
    sram_we    = 1'b0;
    case (state_q)
      STEAL: begin
        owner     = OWN_HOST;
        cpu_ce    = 1'b0;
        host_busy = 1'b1;
      end
      PEND: begin
        owner     = cpu_active ? OWN_CPU : OWN_HOST;
        host_busy = 1'b1;
      end
      default: owner = cpu_active ? OWN_CPU : OWN_NONE;
    endcase
    case (owner)
      OWN_HOST: begin
        sram_addr  = pend_addr_q;
        sram_wdata = pend_wdata_q;
        sram_oe    = ~pend_we_q;
        sram_we    = pend_we_q;
      end
      OWN_CPU: begin
        sram_addr  = cpu_addr;
        sram_wdata = cpu_wdata;
        // a simultaneous read and write resolves to the write
        sram_oe    = cpu_oe & ~cpu_we;
        sram_we    = cpu_we;
      end
      default: begin
        sram_oe = 1'b0;
        sram_we = 1'b0;
      end
    endcase
  end

  // Datapath next values
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    pend_we_d     = pend_we_q;
    pend_addr_d   = pend_addr_q;
    pend_wdata_d  = pend_wdata_q;
    host_ack_d    = 1'b0;
    host_rdata_d  = host_rdata_q;
    steal_count_d = steal_count_q;
    if (state_q == IDLE && host_req) begin
      pend_we_d    = host_we;
      pend_addr_d  = host_addr;
      pend_wdata_d = host_wdata;
      wait_cnt_d   = 8'd0;
    end
    if (state_q == PEND && cpu_active) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    if (owner == OWN_HOST) begin
      host_ack_d = 1'b1;
      if (!pend_we_q) host_rdata_d = sram_rdata;
    end
    if (state_q == STEAL && steal_count_q != {STEAL_CNT_W{1'b1}}) begin
      steal_count_d = steal_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q    <= 8'd0;
      pend_we_q     <= 1'b0;
      pend_addr_q   <= 16'h0000;
      pend_wdata_q  <= 8'h00;
      host_ack_q    <= 1'b0;
      host_rdata_q  <= 8'h00;
      steal_count_q <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      pend_we_q     <= pend_we_d;
      pend_addr_q   <= pend_addr_d;
      pend_wdata_q  <= pend_wdata_d;
      host_ack_q    <= host_ack_d;
      host_rdata_q  <= host_rdata_d;
      steal_count_q <= steal_count_d;
    end
  end

  assign cpu_rdata    = sram_rdata;
  assign host_ack     = host_ack_q;
  assign host_rdata   = host_rdata_q;
  assign steal_count  = steal_count_q;
  assign dbg_state    = state_q;
  assign dbg_wait_cnt = wait_cnt_q;

  a_cpu_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(cpu_oe && cpu_we));

endmodule

// File: tb/tb_gigatron_ram_arbiter.sv
// Bench for gigatron_ram_arbiter: SRAM model, cycle driver with a reference
// model of grant timing and memory contents, and an ack scoreboard.
module tb_gigatron_ram_arbiter;
  import gigatron_arb_pkg::*;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_oe, cpu_we;
  logic [7:0]  cpu_rdata;
  logic        cpu_ce;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_busy, host_ack;
  logic [7:0]  host_rdata;
  logic [15:0] steal_count;
  logic [15:0] sram_addr;
  logic [7:0]  sram_wdata, sram_rdata;
  logic        sram_oe, sram_we;
  arb_state_t  dbg_state;
  logic [7:0]  dbg_wait_cnt;

  gigatron_ram_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .cpu_ce(cpu_ce),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_busy(host_busy), .host_ack(host_ack), .host_rdata(host_rdata),
    .steal_count(steal_count),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_oe(sram_oe), .sram_we(sram_we),
    .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- physical asynchronous SRAM ----------------
  logic [7:0] phys [0:65535];
  assign sram_rdata = phys[sram_addr];
  always @(posedge clk) if (sram_we) phys[sram_addr] <= sram_wdata;

  // ---------------- reference model state ----------------
  logic [7:0]  shadow [0:65535];
  bit          m_pend;
  int unsigned m_n;
  logic        m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic [15:0] m_steals;
  bit          hold_cpu;
  logic        h_oe, h_we;
  logic [15:0] h_addr;
  logic [7:0]  h_wd;

  // scoreboard entry: {is_read, data, ack cycle}
  logic [40:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h cycle=%0d", name, act, exp, cyc + 1);
    end
  endtask

  // One clock cycle: apply inputs, check combinational/registered outputs
  // against the model, then advance the model.
  task automatic drive(input logic oe, input logic we, input logic [15:0] ca,
                       input logic [7:0] cw, input logic rq, input logic rwe,
                       input logic [15:0] ra, input logic [7:0] rwd, input bit do_rst);
    int unsigned t, d;
    bit steal, hgrant, cgrant, accept;
    @(negedge clk);
    t = cyc + 1;
    if (hold_cpu) begin
      oe = h_oe; we = h_we; ca = h_addr; cw = h_wd;
    end
    cpu_oe = oe; cpu_we = we; cpu_addr = ca; cpu_wdata = cw;
    host_req = rq; host_we = rwe; host_addr = ra; host_wdata = rwd;
    accept = !m_pend && rq;
    steal = 1'b0; hgrant = 1'b0; d = 0;
    if (m_pend) begin
      d = t - m_n;
      steal = (d == MW + 1);
      hgrant = steal || !(oe || we);
    end
    cgrant = !hgrant && (oe || we);
    #1;
    chk("cpu_ce", 32'(cpu_ce), 32'(!steal));
    chk("host_busy", 32'(host_busy), 32'(m_pend));
    chk("steal_count", 32'(steal_count), 32'(m_steals));
    if (m_pend) chk("wait_cnt", 32'(dbg_wait_cnt), d - 1);
    if (hgrant) begin
      chk("host_sram_addr", 32'(sram_addr), 32'(m_addr));
      chk("host_sram_oe", 32'(sram_oe), 32'(!m_we));
      chk("host_sram_we", 32'(sram_we), 32'(m_we));
      if (m_we) chk("host_sram_wdata", 32'(sram_wdata), 32'(m_wdata));
    end else if (cgrant) begin
      chk("cpu_sram_addr", 32'(sram_addr), 32'(ca));
      chk("cpu_sram_oe", 32'(sram_oe), 32'(oe));
      chk("cpu_sram_we", 32'(sram_we), 32'(we));
      if (we) chk("cpu_sram_wdata", 32'(sram_wdata), 32'(cw));
      if (oe) chk("cpu_rdata", 32'(cpu_rdata), 32'(shadow[ca]));
    end else begin
      chk("idle_sram_en", 32'({sram_oe, sram_we}), 32'd0);
    end
    if (do_rst && steal) begin
      #2 reset = 1'b1;
      #1;
      chk("rst_cpu_ce", 32'(cpu_ce), 32'd1);
      chk("rst_host_busy", 32'(host_busy), 32'd0);
      chk("rst_host_ack", 32'(host_ack), 32'd0);
      m_pend = 0; m_steals = 16'h0000; hold_cpu = 0;
      cpu_oe = 1'b0; cpu_we = 1'b0; host_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    if (hgrant) begin
      exp_q.push_back({!m_we, m_we ? 8'h00 : shadow[m_addr], t + 1});
      if (m_we) shadow[m_addr] = m_wdata;
      m_pend = 0;
    end
    if (cgrant && we) shadow[ca] = cw;
    if (steal && m_steals != 16'hFFFF) m_steals = m_steals + 16'd1;
    hold_cpu = steal;
    h_oe = oe; h_we = we; h_addr = ca; h_wd = cw;
    if (accept) begin
      m_pend = 1; m_n = t; m_we = rwe; m_addr = ra; m_wdata = rwd;
    end
  endtask

  // ---------------- ack monitor ----------------
  logic [40:0] mon_e;
  int unsigned mon_t;
  always @(negedge clk) begin
    if (!reset) begin
      mon_t = cyc + 1;
      if (host_ack) begin
        if (exp_q.size() == 0) begin
          chk("ack_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_cycle", mon_t, mon_e[31:0]);
          if (mon_e[40]) chk("host_rdata", 32'(host_rdata), 32'(mon_e[39:32]));
        end
      end else if (exp_q.size() > 0 && exp_q[0][31:0] <= mon_t) begin
        mon_e = exp_q.pop_front();
        chk("ack_missing", 32'd0, 32'd1);
      end
    end
  end

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
  endtask

  task automatic cpu_read_cycle(input logic [15:0] a);
    drive(1'b1, 1'b0, a, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int op;
    bit busy_phase;
    for (int i = 0; i < 65536; i++) begin
      phys[i]   = 8'(i * 7 + (i >> 8));
      shadow[i] = 8'(i * 7 + (i >> 8));
    end
    phys[16'h1234] = 8'h5A; shadow[16'h1234] = 8'h5A;
    m_pend = 0; m_steals = 16'h0000; hold_cpu = 0;
    reset = 1'b1;
    cpu_oe = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    repeat (3) @(negedge clk);
    chk("reset_cpu_ce", 32'(cpu_ce), 32'd1);
    chk("reset_host_busy", 32'(host_busy), 32'd0);
    chk("reset_host_ack", 32'(host_ack), 32'd0);
    chk("reset_host_rdata", 32'(host_rdata), 32'd0);
    chk("reset_steal_count", 32'(steal_count), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    chk("reset_sram_en", 32'({sram_oe, sram_we}), 32'd0);
    reset = 1'b0;

    // CPU idle host read of 0x1234
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h1234, 8'h0, 1'b0);
    idle_cycle();
    idle_cycle();
    chk("read_5a_data", 32'(host_rdata), 32'h5A);

    // forced steal: host write 0xA5 to 0x8000 under continuous CPU reads
    drive(1'b1, 1'b0, 16'h0100, 8'h0, 1'b1, 1'b1, 16'h8000, 8'hA5, 1'b0);
    for (int k = 0; k < MW + 2; k++) cpu_read_cycle(16'(16'h0101 + k));
    chk("steal_once", 32'(steal_count), 32'd1);
    idle_cycle();
    chk("steal_write_mem", 32'(phys[16'h8000]), 32'hA5);

    // back-to-back host requests
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0200, 8'h0, 1'b0);
    idle_cycle();
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0201, 8'h3C, 1'b0);
    idle_cycle();
    idle_cycle();

    // CPU priority: CPU write to 0x0010 lands before the pending host read
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0010, 8'h0, 1'b0);
    drive(1'b0, 1'b1, 16'h0010, 8'h11, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    idle_cycle();
    idle_cycle();
    chk("priority_rdata", 32'(host_rdata), 32'h11);

    // reset in the middle of a steal
    drive(1'b1, 1'b0, 16'h0300, 8'h0, 1'b1, 1'b0, 16'h0400, 8'h0, 1'b0);
    for (int k = 0; k < MW; k++) cpu_read_cycle(16'h0300);
    drive(1'b1, 1'b0, 16'h0300, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1);
    repeat (3) idle_cycle();

    // saturation of the steal counter
    force dut.steal_count_q = 16'hFFFE;
    #1 release dut.steal_count_q;
    m_steals = 16'hFFFE;
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 1'b0, 16'h0500, 8'h0, 1'b1, 1'b0, 16'(16'h0600 + s), 8'h0, 1'b0);
      for (int k = 0; k < MW + 2; k++) cpu_read_cycle(16'h0500);
    end
    chk("steal_saturate", 32'(steal_count), 32'hFFFF);

    // randomized traffic on a small address window to force collisions
    busy_phase = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) busy_phase = 1'($urandom_range(0, 1));
      if (busy_phase) op = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 2));
      else op = int'($urandom_range(0, 2));
      drive(op == 1, op == 2, 16'($urandom_range(0, 63)), 8'($urandom),
            $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 63)), 8'($urandom), 1'b0);
    end

    repeat (4) idle_cycle();
    chk("drain_pending_acks", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
